// File: rtl/lut_ram_dist.sv
// Distributed (LUT-style) RAM: one synchronous write port, one combinational read port.
// The async reset clears every entry at once, so the array is a flop bank rather than a true LUTRAM.
module lut_ram_dist #(
  parameter int LUT_WIDTH = 32,
  parameter int LUT_DEPTH = 256
) (
  input  logic                              clk,
  input  logic                              rst_n,
  input  logic                              wr_en,
  input  logic [$clog2(LUT_DEPTH)-1:0]      wr_addr,
  input  logic [$clog2(LUT_DEPTH)-1:0]      rd_addr,
  input  logic [LUT_WIDTH-1:0]              wr_data,
  output logic [LUT_WIDTH-1:0]              rd_data
);

  localparam int ADDR_W = $clog2(LUT_DEPTH);
  localparam bit FULL_RANGE = (LUT_DEPTH == (1 << ADDR_W));

  logic [LUT_WIDTH-1:0] r_mem [LUT_DEPTH];
  logic                 w_wr_ok;
  logic                 w_rd_ok;

  // With a power-of-two depth every address is legal and the range check is dropped.
  if (FULL_RANGE) begin : g_full
    assign w_wr_ok = 1'b1;
    assign w_rd_ok = 1'b1;
  end else begin : g_partial
    assign w_wr_ok = ({1'b0, wr_addr} < (ADDR_W+1)'(LUT_DEPTH));
    assign w_rd_ok = ({1'b0, rd_addr} < (ADDR_W+1)'(LUT_DEPTH));
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < LUT_DEPTH; i++) begin
        r_mem[i] <= '0;
      end
    end else if (wr_en && w_wr_ok) begin
      r_mem[wr_addr] <= wr_data;
    end
  end

  assign rd_data = w_rd_ok ? r_mem[rd_addr] : '0;

endmodule

// File: tb/tb_lut_ram_dist.sv
// Directed and random checks of lut_ram_dist at the default 32x256 configuration.
module tb_lut_ram_dist;

  localparam int LUT_WIDTH = 32;
  localparam int LUT_DEPTH = 256;
  localparam int ADDR_W    = $clog2(LUT_DEPTH);

  logic                 clk = 1'b0;
  logic                 rst_n;
  logic                 wr_en;
  logic [ADDR_W-1:0]    wr_addr;
  logic [ADDR_W-1:0]    rd_addr;
  logic [LUT_WIDTH-1:0] wr_data;
  logic [LUT_WIDTH-1:0] rd_data;

  logic [LUT_WIDTH-1:0] model [LUT_DEPTH];
  int n_vec = 0;
  int n_err = 0;

  lut_ram_dist #(.LUT_WIDTH(LUT_WIDTH), .LUT_DEPTH(LUT_DEPTH)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .wr_en   (wr_en),
    .wr_addr (wr_addr),
    .rd_addr (rd_addr),
    .wr_data (wr_data),
    .rd_data (rd_data)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [LUT_WIDTH-1:0] exp);
    n_vec++;
    assert (rd_data === exp) else begin
      n_err++;
      $error("FAIL %s: rd_data=%h expected=%h", tag, rd_data, exp);
    end
  endtask

  task automatic drive(input logic en, input int wa, input int ra, input logic [LUT_WIDTH-1:0] d);
    wr_en   = en;
    wr_addr = ADDR_W'(wa);
    rd_addr = ADDR_W'(ra);
    wr_data = d;
  endtask

  initial begin
    rst_n = 1'b0;
    drive(1'b0, 0, 5, '0);
    #2;
    check("reset_state", 32'h0);

    @(negedge clk);
    rst_n = 1'b1;
    drive(1'b1, 5, 5, 32'hDEADBEEF);
    @(posedge clk); #1;
    check("write_deadbeef", 32'hDEADBEEF);
    wr_en = 1'b0;
    rst_n = 1'b0;
    #1;
    check("async_clear_in_reset", 32'h0);
    rst_n = 1'b1;
    #1;
    check("async_clear_after_release", 32'h0);

    // Alternating write/read: even steps write i+1, odd steps leave the entry at 0.
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      drive((i % 2) == 0, i*10, i*10, LUT_WIDTH'(i+1));
      @(posedge clk); #1;
      check($sformatf("alt_%0d", i*10), ((i % 2) == 0) ? LUT_WIDTH'(i+1) : 32'h0);
    end

    @(negedge clk);
    drive(1'b1, 7, 7, 32'hA5A5A5A5);
    #1;
    check("same_addr_before_edge", 32'h0);
    @(posedge clk); #1;
    check("same_addr_after_edge", 32'hA5A5A5A5);

    @(negedge clk);
    drive(1'b1, 3, 0, 32'h11);
    @(negedge clk);
    drive(1'b1, 4, 0, 32'h22);
    @(posedge clk); #1;
    wr_en   = 1'b0;
    rd_addr = 8'd3;
    #1;
    check("async_read_3", 32'h11);
    rd_addr = 8'd4;
    #1;
    check("async_read_4", 32'h22);

    @(negedge clk);
    drive(1'b0, 3, 3, 32'hFF);
    @(posedge clk); #1;
    check("wr_disabled_hold", 32'h11);

    @(negedge clk);
    drive(1'b1, 255, 254, 32'hFFFFFFFF);
    @(posedge clk); #1;
    check("isolation_254", 32'h0);
    wr_en   = 1'b0;
    rd_addr = 8'd255;
    #1;
    check("top_addr_255", 32'hFFFFFFFF);

    // Reset asserted before an edge with a write pending: the write is lost.
    @(negedge clk);
    drive(1'b1, 9, 9, 32'h99);
    rst_n = 1'b0;
    @(posedge clk); #1;
    check("write_blocked_in_reset", 32'h0);
    rd_addr = 8'd255;
    #1;
    check("clear_255_mid_op", 32'h0);
    @(negedge clk);
    wr_en = 1'b0;
    rst_n = 1'b1;
    rd_addr = 8'd7;
    #1;
    check("clear_7_after_release", 32'h0);

    for (int i = 0; i < LUT_DEPTH; i++) model[i] = '0;

    for (int c = 0; c < 1000; c++) begin
      @(negedge clk);
      drive(1'($urandom_range(0, 1)), int'($urandom_range(0, LUT_DEPTH-1)),
            int'($urandom_range(0, LUT_DEPTH-1)), LUT_WIDTH'($urandom));
      // Bias reads toward the address being written to exercise read-during-write.
      if ($urandom_range(0, 3) == 0) rd_addr = wr_addr;
      @(posedge clk);
      if (wr_en) model[wr_addr] = wr_data;
      #1;
      check("random", model[rd_addr]);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
